high_bit_search_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational high-bit search. It accepts a stream of `INPUT_WIDTH`-bit words over a valid/ready handshake. For each word it returns the index of the most-significant set bit (mode 0) or the least-significant set bit (mode 1), plus a zero flag and a pass-through tag. It sits between a producer of bitmaps (arbiter requests, normalisation shifts) and its consumer, with fixed two-cycle latency and full backpressure.

---
 rtl/high_bit_search_pipe.sv | 106 ++++++++++
 tb/tb_high_bit_search_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/high_bit_search_pipe.sv
// Two-stage pipelined most/least-significant set-bit search with valid/ready flow control.
// Stage 1 reduces each chunk to (any, local index); stage 2 picks the winning chunk.
module high_bit_search_pipe #(
   parameter int INPUT_WIDTH = 32,
   parameter int CHUNK_WIDTH = 8,
   parameter int TAG_WIDTH   = 4,
   localparam int IDX_W      = $clog2(INPUT_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INPUT_WIDTH-1:0] input_data,
   input  logic                   in_mode,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [IDX_W-1:0]       out_index,
   output logic                   out_zero,
   output logic                   out_mode,
   output logic [TAG_WIDTH-1:0]   out_tag,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int N_CHUNK = INPUT_WIDTH / CHUNK_WIDTH;
   localparam int LOC_W   = $clog2(CHUNK_WIDTH);

   // Scan order: ascending positions for mode 0 (last hit = highest), descending for mode 1.
   function automatic int scan_pos(input int i, input logic mode, input int n);
      return (mode == 1'b1) ? (n - 1 - i) : i;
   endfunction

   function automatic logic [LOC_W-1:0] chunk_loc(input logic [CHUNK_WIDTH-1:0] bits,
                                                  input logic mode);
      logic [LOC_W-1:0] loc;
      int               p;
      loc = '0;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
         p   = scan_pos(i, mode, CHUNK_WIDTH);
         loc = bits[p] ? LOC_W'(p) : loc;
      end
      return loc;
   endfunction

   logic [N_CHUNK-1:0]            any_s;
   logic [N_CHUNK-1:0][LOC_W-1:0] loc_s;
   logic [IDX_W-1:0]              sel_index_s;
   logic                          stall_s;

   logic                          s1_valid_r;
   logic [N_CHUNK-1:0]            s1_any_r;
   logic [N_CHUNK-1:0][LOC_W-1:0] s1_loc_r;
   logic                          s1_mode_r;
   logic [TAG_WIDTH-1:0]          s1_tag_r;

   assign stall_s  = out_valid & ~out_ready;
   assign in_ready = ~rst & ~stall_s;

   // Per-chunk occupancy and local bit position of the incoming word.
   always_comb begin
      any_s = '0;
      loc_s = '0;
      for (int c = 0; c < N_CHUNK; c++) begin
         any_s[c] = |input_data[c*CHUNK_WIDTH +: CHUNK_WIDTH];
         loc_s[c] = chunk_loc(input_data[c*CHUNK_WIDTH +: CHUNK_WIDTH], in_mode);
      end
   end

   // Winning chunk: chunk index forms the upper index bits, local position the lower ones.
   always_comb begin
      sel_index_s = '0;
      for (int i = 0; i < N_CHUNK; i++) begin
         sel_index_s = s1_any_r[scan_pos(i, s1_mode_r, N_CHUNK)]
                     ? (IDX_W'(scan_pos(i, s1_mode_r, N_CHUNK) * CHUNK_WIDTH)
                        + IDX_W'(s1_loc_r[scan_pos(i, s1_mode_r, N_CHUNK)]))
                     : sel_index_s;
      end
   end

   // Pipeline registers; both stages freeze together while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_any_r   <= '0;
         s1_loc_r   <= '0;
         s1_mode_r  <= 1'b0;
         s1_tag_r   <= '0;
         out_valid  <= 1'b0;
         out_index  <= '0;
         out_zero   <= 1'b0;
         out_mode   <= 1'b0;
         out_tag    <= '0;
      end else if (!stall_s) begin
         s1_valid_r <= in_valid & in_ready;
         s1_any_r   <= any_s;
         s1_loc_r   <= loc_s;
         s1_mode_r  <= in_mode;
         s1_tag_r   <= in_tag;
         out_valid  <= s1_valid_r;
         out_index  <= sel_index_s;
         out_zero   <= ~|s1_any_r;
         out_mode   <= s1_mode_r;
         out_tag    <= s1_tag_r;
      end
   end

endmodule

// File: tb/tb_high_bit_search_pipe.sv
// Randomised + directed bench for high_bit_search_pipe: one 32/8 instance and three
// 64-bit instances (chunk 2, 8, 64) checked against a scoreboard model.
module tb_high_bit_search_pipe;

   typedef struct packed {
      logic [5:0]  idx;
      logic        zero;
      logic        mode;
      logic [3:0]  tag;
      logic [31:0] cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        o_ready;
   logic [31:0] d_data;
   logic        d_mode, d_valid, d_in_ready;
   logic [3:0]  d_tag, d_tag_o;
   logic [4:0]  d_idx;
   logic        d_zero, d_mode_o, d_out_valid;

   logic [63:0] w_data;
   logic        w_mode, w_valid;
   logic [3:0]  w_tag;
   logic [2:0]  w_in_ready, w_zero, w_mode_o, w_out_valid;
   logic [5:0]  w_idx [3];
   logic [3:0]  w_tag_o [3];

   high_bit_search_pipe #(.INPUT_WIDTH(32), .CHUNK_WIDTH(8), .TAG_WIDTH(4)) u_dut (
      .clk(clk), .rst(rst), .input_data(d_data), .in_mode(d_mode), .in_tag(d_tag),
      .in_valid(d_valid), .in_ready(d_in_ready), .out_index(d_idx), .out_zero(d_zero),
      .out_mode(d_mode_o), .out_tag(d_tag_o), .out_valid(d_out_valid), .out_ready(o_ready)
   );

   for (genvar k = 0; k < 3; k++) begin : g_w
      high_bit_search_pipe #(
         .INPUT_WIDTH(64),
         .CHUNK_WIDTH((k == 0) ? 2 : ((k == 1) ? 8 : 64)),
         .TAG_WIDTH(4)
      ) u_dut (
         .clk(clk), .rst(rst), .input_data(w_data), .in_mode(w_mode), .in_tag(w_tag),
         .in_valid(w_valid), .in_ready(w_in_ready[k]), .out_index(w_idx[k]),
         .out_zero(w_zero[k]), .out_mode(w_mode_o[k]), .out_tag(w_tag_o[k]),
         .out_valid(w_out_valid[k]), .out_ready(o_ready)
      );
   end

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   stall_left;
   bit   rand_ready, lat_chk, ov_en, acc32, acc64;
   logic [5:0] ov_idx;
   logic       ov_zero;
   exp_t q32[$];
   exp_t q64[3][$];

   task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, exp_v, cyc);
      end
   endtask

   // Reference: plain bit scan, or a directed constant when ov_en is set.
   function automatic exp_t make_exp(input logic [63:0] d, input logic m, input logic [3:0] t,
                                     input int w);
      exp_t e;
      e.idx  = 6'd0;
      e.zero = 1'b1;
      e.mode = m;
      e.tag  = t;
      e.cyc  = 32'(cyc);
      if (ov_en) begin
         e.idx  = ov_idx;
         e.zero = ov_zero;
      end else begin
         for (int i = 0; i < w; i++) begin
            if (d[i]) begin
               if (!m || e.zero) e.idx = 6'(i);
               e.zero = 1'b0;
            end
         end
      end
      return e;
   endfunction

   function automatic logic [63:0] rand_word(input int w);
      logic [63:0] d;
      case ($urandom_range(0, 3))
         0:       d = {$urandom, $urandom};
         1:       d = 64'd1 << $urandom_range(0, w - 1);
         2:       d = 64'd0;
         default: d = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      if (w == 32) d[63:32] = 32'd0;
      return d;
   endfunction

   task automatic tick();
      exp_t e;
      if (stall_left > 0) begin
         o_ready = 1'b0;
         stall_left--;
      end else if (rand_ready) o_ready = 1'($urandom_range(0, 1));
      else o_ready = 1'b1;
      #1;
      acc32 = 1'b0;
      acc64 = 1'b0;
      if (rst) begin
         check_eq("in_ready_rst", 64'(d_in_ready), 64'd0);
         check_eq("w_in_ready_rst", 64'(w_in_ready), 64'd0);
      end else begin
         check_eq("in_ready", 64'(d_in_ready), 64'(!(d_out_valid && !o_ready)));
         if (d_out_valid && o_ready) begin
            if (q32.size() == 0) check_eq("spurious32", 64'(d_out_valid), 64'd0);
            else begin
               e = q32.pop_front();
               check_eq("idx32", 64'(d_idx), 64'(e.idx));
               check_eq("zero32", 64'(d_zero), 64'(e.zero));
               check_eq("mode32", 64'(d_mode_o), 64'(e.mode));
               check_eq("tag32", 64'(d_tag_o), 64'(e.tag));
               if (lat_chk) check_eq("lat32", 64'(32'(cyc) - e.cyc), 64'd2);
            end
         end
         if (d_valid && d_in_ready) begin
            q32.push_back(make_exp(64'(d_data), d_mode, d_tag, 32));
            acc32 = 1'b1;
         end
         for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("w%0d_in_ready", k), 64'(w_in_ready[k]),
                     64'(!(w_out_valid[k] && !o_ready)));
            if (w_out_valid[k] && o_ready) begin
               if (q64[k].size() == 0)
                  check_eq($sformatf("w%0d_spurious", k), 64'(w_out_valid[k]), 64'd0);
               else begin
                  e = q64[k].pop_front();
                  check_eq($sformatf("w%0d_idx", k), 64'(w_idx[k]), 64'(e.idx));
                  check_eq($sformatf("w%0d_zero", k), 64'(w_zero[k]), 64'(e.zero));
                  check_eq($sformatf("w%0d_mode", k), 64'(w_mode_o[k]), 64'(e.mode));
                  check_eq($sformatf("w%0d_tag", k), 64'(w_tag_o[k]), 64'(e.tag));
                  if (lat_chk) check_eq($sformatf("w%0d_lat", k), 64'(32'(cyc) - e.cyc), 64'd2);
               end
            end
            if (w_valid && w_in_ready[k]) q64[k].push_back(make_exp(w_data, w_mode, w_tag, 64));
         end
         acc64 = w_valid && (&w_in_ready);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic send32(input logic [31:0] d, input logic m, input logic [3:0] t);
      d_valid = 1'b1; d_data = d; d_mode = m; d_tag = t;
      for (int n = 0; n < 50; n++) begin
         tick();
         if (acc32) return;
      end
      check_eq("send32_timeout", 64'(acc32), 64'd1);
   endtask

   task automatic send64(input logic [63:0] d, input logic m, input logic [3:0] t);
      w_valid = 1'b1; w_data = d; w_mode = m; w_tag = t;
      for (int n = 0; n < 50; n++) begin
         tick();
         if (acc64) return;
      end
      check_eq("send64_timeout", 64'(acc64), 64'd1);
   endtask

   task automatic drain();
      d_valid = 1'b0;
      w_valid = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (q32.size() == 0 && q64[0].size() == 0 && q64[1].size() == 0 && q64[2].size() == 0)
            break;
         tick();
      end
      tick();
      tick();
      check_eq("drain32", 64'(q32.size()), 64'd0);
      for (int k = 0; k < 3; k++) check_eq($sformatf("w%0d_drain", k), 64'(q64[k].size()), 64'd0);
   endtask

   task automatic check_reset_state(input string name);
      check_eq({name, "_valid"}, 64'(d_out_valid), 64'd0);
      check_eq({name, "_index"}, 64'(d_idx), 64'd0);
      check_eq({name, "_zero"}, 64'(d_zero), 64'd0);
      check_eq({name, "_mode"}, 64'(d_mode_o), 64'd0);
      check_eq({name, "_tag"}, 64'(d_tag_o), 64'd0);
      check_eq({name, "_in_ready"}, 64'(d_in_ready), 64'd1);
      check_eq({name, "_w_valid"}, 64'(w_out_valid), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] words [5];
      logic [5:0]  hi [5];
      logic [5:0]  lo [5];
      words = '{32'hDEADBEEF, 32'h00005403, 32'h005030BE, 32'h00000024, 32'hFEFA14DE};
      hi    = '{6'd31, 6'd14, 6'd22, 6'd5, 6'd31};
      lo    = '{6'd0, 6'd0, 6'd1, 6'd2, 6'd1};
      rst = 1'b1; o_ready = 1'b1; stall_left = 0; rand_ready = 1'b0;
      d_valid = 1'b0; d_data = 32'd0; d_mode = 1'b0; d_tag = 4'd0;
      w_valid = 1'b0; w_data = 64'd0; w_mode = 1'b0; w_tag = 4'd0;
      ov_en = 1'b1; ov_idx = 6'd0; ov_zero = 1'b0; lat_chk = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_reset_state("reset");

      // Directed words: mode 0, mode 1, then alternating per word.
      for (int pass = 0; pass < 3; pass++) begin
         for (int i = 0; i < 5; i++) begin
            logic m;
            m = (pass == 0) ? 1'b0 : ((pass == 1) ? 1'b1 : 1'(i % 2));
            ov_idx  = m ? lo[i] : hi[i];
            ov_zero = 1'b0;
            send32(words[i], m, 4'(i + 5 * pass));
         end
         drain();
      end

      // Boundary words in both modes.
      for (int m = 0; m < 2; m++) begin
         ov_idx = 6'd0;  ov_zero = 1'b1; send32(32'h00000000, 1'(m), 4'd1);
         ov_idx = 6'd31; ov_zero = 1'b0; send32(32'h80000000, 1'(m), 4'd2);
         ov_idx = 6'd0;  ov_zero = 1'b0; send32(32'h00000001, 1'(m), 4'd3);
      end
      drain();

      // 64-bit word across all chunk widths.
      ov_zero = 1'b0;
      ov_idx = 6'd40; send64(64'h0000_0100_0000_8000, 1'b0, 4'd9);
      ov_idx = 6'd15; send64(64'h0000_0100_0000_8000, 1'b1, 4'd10);
      drain();

      // Backpressure: three-cycle consumer stall in the middle of six tagged words.
      ov_en = 1'b0;
      lat_chk = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) stall_left = 3;
         send32(rand_word(32)[31:0] | 32'h00010000, 1'($urandom_range(0, 1)), 4'(i));
      end
      drain();

      // Reset with two words in flight; nothing stale may emerge afterwards.
      lat_chk = 1'b1;
      send32(32'h00F0_0000, 1'b0, 4'd1);
      send32(32'h0000_0F00, 1'b1, 4'd2);
      d_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q32.delete();
      for (int k = 0; k < 3; k++) q64[k].delete();
      #1;
      check_reset_state("midrst");
      send32(32'h0004_2000, 1'b1, 4'd7);
      drain();

      // Random streams with random consumer readiness.
      lat_chk = 1'b0;
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++)
         send32(rand_word(32)[31:0], 1'($urandom_range(0, 1)), 4'($urandom));
      drain();
      for (int i = 0; i < 1000; i++)
         send64(rand_word(64), 1'($urandom_range(0, 1)), 4'($urandom));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
